cpu_control_fsm: RTL and testbench

Multicycle control sequencer for the IITB-CPU core. It reads the 8-bit opcode byte of the instruction register and steps fetch, decode, execute, memory and writeback. It drives the per-cycle enables of the PC, IR, register file, ALU and memory port, and handshakes with memory through a req/ack pair. It also keeps a retired-instruction counter and a memory-timeout watchdog that halts the core on a stuck bus.

---
 rtl/cpu_control_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multicycle control sequencer: fetch/decode/exec/mem/wb with req/ack memory port and bus watchdog.
// Latency: 3-5 cycles per instruction plus one per memory wait cycle; enables decode from state.
// Backpressure: mem_req held until mem_ack; TIMEOUT cycles without ack raises bus_err and halts.
module cpu_control_fsm #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ir_opcode,
    input  logic        alu_zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic [1:0]  alu_mode,
    output logic        alu_en,
    output logic        halted,
    output logic        bus_err,
    output logic [15:0] retired,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_MEM  = 2'd1;
    localparam logic [1:0] WSEL_LINK = 2'd2;

    localparam logic [1:0] ALU_OPC   = 2'd0;
    localparam logic [1:0] ALU_ADD   = 2'd1;
    localparam logic [1:0] ALU_SUB   = 2'd2;

    localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);

    state_t      cur_st;
    state_t      nxt_st;
    logic [7:0]  wd_cnt;

    logic        is_alu;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        is_nop;
    logic        is_jal;
    logic        is_halt;
    logic        br_taken;
    logic        in_mem_st;
    logic        wd_fire;
    logic        retire;
    logic        unused_opbits;

    assign unused_opbits = &{1'b0, ir_opcode[3:2]};

    // Opcode class decode; the 0xF group folds into jump / jal / nop / halt.
    always_comb begin
        is_alu    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_nop    = 1'b0;
        is_jal    = 1'b0;
        is_halt   = 1'b0;
        case (ir_opcode[7:4])
            4'h4: is_load   = 1'b1;
            4'h5: is_store  = 1'b1;
            4'hC: is_branch = 1'b1;
            4'hD: is_jump   = 1'b1;
            4'hE: is_nop    = 1'b1;
            4'hF: begin
                case (ir_opcode[1:0])
                    2'b00:   is_jump = 1'b1;
                    2'b01:   is_jal  = 1'b1;
                    2'b10:   is_nop  = 1'b1;
                    default: is_halt = 1'b1;
                endcase
            end
            default: is_alu = 1'b1;
        endcase
    end

    assign br_taken  = ir_opcode[0] ? ~alu_zero : alu_zero;
    assign in_mem_st = (cur_st == S_FETCH) || (cur_st == S_MEM);

    // An ack in the expiring cycle wins over the timeout.
    assign wd_fire   = in_mem_st && !mem_ack && (wd_cnt == WD_LAST);

    assign retire = ((cur_st == S_EXEC) && (is_branch || is_jump || is_nop || is_jal || is_halt))
                 || ((cur_st == S_MEM) && is_store && mem_ack)
                 ||  (cur_st == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st  <= S_RESET;
            wd_cnt  <= 8'd0;
            retired <= 16'd0;
            halted  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            cur_st  <= nxt_st;
            if (in_mem_st && !mem_ack && !wd_fire) begin
                wd_cnt <= wd_cnt + 8'd1;
            end else begin
                wd_cnt <= 8'd0;
            end
            retired <= retired + 16'(retire);
            if (nxt_st == S_HALT) begin
                halted <= 1'b1;
            end
            if (wd_fire) begin
                bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            S_RESET:  nxt_st = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    nxt_st = S_DECODE;
                end else if (wd_fire) begin
                    nxt_st = S_HALT;
                end
            end
            S_DECODE: nxt_st = S_EXEC;
            S_EXEC: begin
                if (is_alu) begin
                    nxt_st = S_WB;
                end else if (is_load || is_store) begin
                    nxt_st = S_MEM;
                end else if (is_halt) begin
                    nxt_st = S_HALT;
                end else begin
                    nxt_st = S_FETCH;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    nxt_st = is_load ? S_WB : S_FETCH;
                end else if (wd_fire) begin
                    nxt_st = S_HALT;
                end
            end
            S_WB:     nxt_st = S_FETCH;
            S_HALT:   nxt_st = S_HALT;
            default:  nxt_st = S_RESET;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_INC;
        rf_we        = 1'b0;
        rf_wsel      = WSEL_ALU;
        alu_mode     = ALU_OPC;
        alu_en       = 1'b0;
        case (cur_st)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_alu) begin
                    alu_en = 1'b1;
                end else if (is_load || is_store) begin
                    alu_mode = ALU_ADD;
                    alu_en   = 1'b1;
                end else if (is_branch) begin
                    alu_mode = ALU_SUB;
                    if (br_taken) begin
                        pc_we  = 1'b1;
                        pc_src = PC_BRANCH;
                    end
                end else if (is_jump) begin
                    pc_we  = 1'b1;
                    pc_src = PC_JUMP;
                end else if (is_jal) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_JUMP;
                    rf_we   = 1'b1;
                    rf_wsel = WSEL_LINK;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wsel = is_load ? WSEL_MEM : WSEL_ALU;
            end
            default: ;
        endcase
    end

    assign state = cur_st;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: one task per scenario with inline expected values.
module tb_cpu_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ir_opcode = 8'h00;
    logic        alu_zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0]  pc_src, rf_wsel, alu_mode;
    logic        rf_we, alu_en, halted, bus_err;
    logic [15:0] retired;
    logic [2:0]  state;
    logic [14:0] outs;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_ret = 16'd0;

    cpu_control_fsm #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .alu_zero(alu_zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .rf_wsel(rf_wsel), .alu_mode(alu_mode),
        .alu_en(alu_en), .halted(halted), .bus_err(bus_err), .retired(retired), .state(state)
    );

    assign outs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, rf_we, rf_wsel,
                   alu_mode, alu_en, halted, bus_err};

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; mem_ack = 1'b0; alu_zero = 1'b0; ir_opcode = 8'h00;
        step; step;
        rst_n = 1'b1;
        step;
        exp_ret = 16'd0;
    endtask

    // Leaves the DUT in EXEC with the given opcode, fetch acked in its first cycle.
    task automatic fetch_decode(input logic [7:0] op);
        ir_opcode = op; mem_ack = 1'b1;
        step;
        mem_ack = 1'b0;
        step;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_ack = 1'b1; alu_zero = 1'b1; ir_opcode = 8'hF1;
        step; #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0h expected 0", retired); end
        checks++; if (outs !== 15'd0) begin errors++; $display("FAIL reset_outs: got %0h expected 0", outs); end
        mem_ack = 1'b0; alu_zero = 1'b0; rst_n = 1'b1;
        step; #1;
        checks++; if ({state, mem_req, mem_we, mem_addr_sel, ir_we} !== {3'd1, 4'b1000})
            begin errors++; $display("FAIL release_fetch: got %0h expected %0h", {state, mem_req, mem_we, mem_addr_sel, ir_we}, {3'd1, 4'b1000}); end
        exp_ret = 16'd0;
    endtask

    task automatic test_alu;
        ir_opcode = 8'h12; mem_ack = 1'b1; #1;
        checks++; if ({state, ir_we, pc_we, pc_src} !== {3'd1, 1'b1, 1'b1, 2'd0})
            begin errors++; $display("FAIL alu_fetch: got %0h expected %0h", {state, ir_we, pc_we, pc_src}, {3'd1, 1'b1, 1'b1, 2'd0}); end
        step; mem_ack = 1'b0; #1;
        checks++; if ({state, outs} !== {3'd2, 15'd0}) begin errors++; $display("FAIL alu_decode: got %0h expected %0h", {state, outs}, {3'd2, 15'd0}); end
        step; #1;
        checks++; if ({state, alu_en, alu_mode, rf_we} !== {3'd3, 1'b1, 2'd0, 1'b0})
            begin errors++; $display("FAIL alu_exec: got %0h expected %0h", {state, alu_en, alu_mode, rf_we}, {3'd3, 1'b1, 2'd0, 1'b0}); end
        step; #1;
        checks++; if ({state, rf_we, rf_wsel, retired} !== {3'd5, 1'b1, 2'd0, 16'd0})
            begin errors++; $display("FAIL alu_wb: got %0h expected %0h", {state, rf_we, rf_wsel, retired}, {3'd5, 1'b1, 2'd0, 16'd0}); end
        step; #1;
        checks++; if ({state, retired} !== {3'd1, 16'd1}) begin errors++; $display("FAIL alu_retire: got %0h expected %0h", {state, retired}, {3'd1, 16'd1}); end
        exp_ret = 16'd1;
    endtask

    task automatic test_load;
        fetch_decode(8'h40); #1;
        checks++; if ({state, alu_mode, alu_en} !== {3'd3, 2'd1, 1'b1})
            begin errors++; $display("FAIL load_exec: got %0h expected %0h", {state, alu_mode, alu_en}, {3'd3, 2'd1, 1'b1}); end
        step;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3); #1;
            checks++; if ({state, mem_req, mem_addr_sel, mem_we} !== {3'd4, 1'b1, 1'b1, 1'b0})
                begin errors++; $display("FAIL load_mem_wait%0d: got %0h expected %0h", i, {state, mem_req, mem_addr_sel, mem_we}, {3'd4, 3'b110}); end
            step;
        end
        mem_ack = 1'b0; #1;
        checks++; if ({state, rf_we, rf_wsel} !== {3'd5, 1'b1, 2'd1})
            begin errors++; $display("FAIL load_wb: got %0h expected %0h", {state, rf_we, rf_wsel}, {3'd5, 1'b1, 2'd1}); end
        step; #1;
        exp_ret = exp_ret + 16'd1;
        checks++; if ({state, retired} !== {3'd1, exp_ret}) begin errors++; $display("FAIL load_retire: got %0h expected %0h", {state, retired}, {3'd1, exp_ret}); end
    endtask

    task automatic test_store;
        fetch_decode(8'h50);
        step; mem_ack = 1'b1; #1;
        checks++; if ({state, mem_req, mem_addr_sel, mem_we, retired} !== {3'd4, 3'b111, exp_ret})
            begin errors++; $display("FAIL store_mem: got %0h expected %0h", {state, mem_req, mem_addr_sel, mem_we, retired}, {3'd4, 3'b111, exp_ret}); end
        step; mem_ack = 1'b0; #1;
        exp_ret = exp_ret + 16'd1;
        checks++; if ({state, retired} !== {3'd1, exp_ret}) begin errors++; $display("FAIL store_retire: got %0h expected %0h", {state, retired}, {3'd1, exp_ret}); end
    endtask

    task automatic test_branch;
        logic [7:0] ops   [4] = '{8'hC0, 8'hC0, 8'hC1, 8'hC1};
        logic       zs    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0] exp_v [4] = '{3'b101, 3'b000, 3'b101, 3'b000};
        for (int i = 0; i < 4; i++) begin
            fetch_decode(ops[i]);
            alu_zero = zs[i]; #1;
            checks++; if ({pc_we, pc_src, alu_mode} !== {exp_v[i], 2'd2})
                begin errors++; $display("FAIL branch%0d_exec: got %0h expected %0h", i, {pc_we, pc_src, alu_mode}, {exp_v[i], 2'd2}); end
            step; alu_zero = 1'b0; #1;
            exp_ret = exp_ret + 16'd1;
            checks++; if ({state, retired} !== {3'd1, exp_ret}) begin errors++; $display("FAIL branch%0d_retire: got %0h expected %0h", i, {state, retired}, {3'd1, exp_ret}); end
        end
    endtask

    task automatic test_jumps;
        logic [7:0] ops   [5] = '{8'hD0, 8'hF0, 8'hF1, 8'hE0, 8'hF2};
        // {pc_we, pc_src, rf_we, rf_wsel}
        logic [5:0] exp_v [5] = '{6'b1_10_0_00, 6'b1_10_0_00, 6'b1_10_1_10, 6'b0_00_0_00, 6'b0_00_0_00};
        for (int i = 0; i < 5; i++) begin
            fetch_decode(ops[i]); #1;
            checks++; if ({pc_we, pc_src, rf_we, rf_wsel} !== exp_v[i])
                begin errors++; $display("FAIL jump%0d_exec: got %0h expected %0h", i, {pc_we, pc_src, rf_we, rf_wsel}, exp_v[i]); end
            step; #1;
            exp_ret = exp_ret + 16'd1;
            checks++; if ({state, retired} !== {3'd1, exp_ret}) begin errors++; $display("FAIL jump%0d_retire: got %0h expected %0h", i, {state, retired}, {3'd1, exp_ret}); end
        end
    endtask

    task automatic test_halt;
        fetch_decode(8'hF3); #1;
        checks++; if ({state, outs} !== {3'd3, 15'd0}) begin errors++; $display("FAIL halt_exec: got %0h expected %0h", {state, outs}, {3'd3, 15'd0}); end
        step; #1;
        exp_ret = exp_ret + 16'd1;
        checks++; if ({state, halted, retired} !== {3'd6, 1'b1, exp_ret})
            begin errors++; $display("FAIL halt_enter: got %0h expected %0h", {state, halted, retired}, {3'd6, 1'b1, exp_ret}); end
        for (int i = 0; i < 20; i++) begin
            mem_ack = i[0]; step; #1;
            checks++; if ({state, mem_req, halted} !== {3'd6, 1'b0, 1'b1})
                begin errors++; $display("FAIL halt_hold%0d: got %0h expected %0h", i, {state, mem_req, halted}, {3'd6, 2'b01}); end
        end
        mem_ack = 1'b0;
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL halt_retired: got %0h expected %0h", retired, exp_ret); end
    endtask

    task automatic test_watchdog;
        apply_reset;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++; if ({state, bus_err} !== {3'd1, 1'b0}) begin errors++; $display("FAIL wd_wait%0d: got %0h expected %0h", i, {state, bus_err}, {3'd1, 1'b0}); end
            step;
        end
        #1;
        checks++; if ({state, bus_err, mem_req} !== {3'd1, 1'b0, 1'b1})
            begin errors++; $display("FAIL wd_cycle16: got %0h expected %0h", {state, bus_err, mem_req}, {3'd1, 2'b01}); end
        step; #1;
        checks++; if ({state, bus_err, halted, ir_we, retired} !== {3'd6, 1'b1, 1'b1, 1'b0, 16'd0})
            begin errors++; $display("FAIL wd_fire: got %0h expected %0h", {state, bus_err, halted, ir_we, retired}, {3'd6, 3'b110, 16'd0}); end
    endtask

    task automatic test_ack_at_timeout;
        apply_reset;
        fetch_decode(8'h40);
        step;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++; if ({state, bus_err} !== {3'd4, 1'b0}) begin errors++; $display("FAIL ackto_wait%0d: got %0h expected %0h", i, {state, bus_err}, {3'd4, 1'b0}); end
            step;
        end
        mem_ack = 1'b1;
        step; mem_ack = 1'b0; #1;
        checks++; if ({state, bus_err, halted} !== {3'd5, 1'b0, 1'b0})
            begin errors++; $display("FAIL ackto_wb: got %0h expected %0h", {state, bus_err, halted}, {3'd5, 2'b00}); end
        step; #1;
        checks++; if ({state, retired} !== {3'd1, 16'd1}) begin errors++; $display("FAIL ackto_retire: got %0h expected %0h", {state, retired}, {3'd1, 16'd1}); end
    endtask

    task automatic test_reset_mid_mem;
        fetch_decode(8'h40);
        step; #1;
        checks++; if ({state, mem_req} !== {3'd4, 1'b1}) begin errors++; $display("FAIL rstmem_pre: got %0h expected %0h", {state, mem_req}, {3'd4, 1'b1}); end
        rst_n = 1'b0; mem_ack = 1'b1; #1;
        checks++; if ({state, outs, retired} !== {3'd0, 15'd0, 16'd0})
            begin errors++; $display("FAIL rstmem_drop: got %0h expected 0", {state, outs, retired}); end
        step; mem_ack = 1'b0; rst_n = 1'b1; #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rstmem_hold: got %0d expected 0", state); end
        step; #1;
        checks++; if ({state, mem_req, mem_addr_sel} !== {3'd1, 1'b1, 1'b0})
            begin errors++; $display("FAIL rstmem_fetch: got %0h expected %0h", {state, mem_req, mem_addr_sel}, {3'd1, 2'b10}); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_load;
        test_store;
        test_branch;
        test_jumps;
        test_halt;
        test_watchdog;
        test_ack_at_timeout;
        test_reset_mid_mem;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
